// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared opcode, funct, Tnew/Tuse encodings and stage entry type
package hazard_scoreboard_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MOVZ  = 6'h0a;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // Tnew: cycles until the result can be forwarded
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Tuse: cycles until the operand is consumed; 3 marks an unused operand
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] dest;
    logic [1:0] tnew;
  } stageEntry_t;

  // One pipeline step closer to ready, never below zero
  function automatic logic [1:0] tnewDec(input logic [1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - D-stage instruction in, stall and stage destinations out
interface hazard_scoreboard_if;
  logic [31:0] Instr_D;
  logic        stall;
  logic [4:0]  Write_E;
  logic [4:0]  Write_M;
  logic [4:0]  Write_W;
  logic [1:0]  Tnew_E;
  logic [1:0]  Tnew_M;
  logic        md_busy;

  modport master (
    output Instr_D,
    input  stall, Write_E, Write_M, Write_W, Tnew_E, Tnew_M, md_busy
  );

  modport slave (
    input  Instr_D,
    output stall, Write_E, Write_M, Write_W, Tnew_E, Tnew_M, md_busy
  );
endinterface

// File: rtl/hazard_decode.sv
// rtl/hazard_decode.sv - combinational D decode into dest, Tnew, Tuse and muldiv info
module hazard_decode
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic [31:0] instr,
  output logic [4:0]  dest,
  output logic [1:0]  tnew,
  output logic [1:0]  tuseRs,
  output logic [1:0]  tuseRt,
  output logic        isMd,
  output logic [3:0]  mdLen
);

  localparam logic [3:0] MULT_LEN = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LEN  = 4'(DIV_CYCLES);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] rawDest;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  // rs and shamt only matter to the scoreboard compare, not to classification
  logic unusedFields;
  assign unusedFields = ^{instr[25:21], instr[10:6]};

  // Classify the instruction; a $0 destination collapses to an empty entry
  always_comb begin
    rawDest = '0;
    dest    = '0;
    tnew    = TNEW_0;
    tuseRs  = TUSE_NONE;
    tuseRt  = TUSE_NONE;
    isMd    = 1'b0;
    mdLen   = '0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU, FN_SUBU, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV, FN_MOVZ: begin
            rawDest = rd; tnew = TNEW_1; tuseRs = TUSE_1; tuseRt = TUSE_1;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            rawDest = rd; tnew = TNEW_1; tuseRt = TUSE_1;
          end
          FN_MFHI, FN_MFLO: begin
            rawDest = rd; tnew = TNEW_1; isMd = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            tuseRs = TUSE_1; isMd = 1'b1;
          end
          FN_MULT, FN_MULTU: begin
            tuseRs = TUSE_1; tuseRt = TUSE_1; isMd = 1'b1; mdLen = MULT_LEN;
          end
          FN_DIV, FN_DIVU: begin
            tuseRs = TUSE_1; tuseRt = TUSE_1; isMd = 1'b1; mdLen = DIV_LEN;
          end
          FN_JR: tuseRs = TUSE_0;
          FN_JALR: begin
            rawDest = rd; tnew = TNEW_0; tuseRs = TUSE_0;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        rawDest = rt; tnew = TNEW_1; tuseRs = TUSE_1;
      end
      OP_LUI: begin
        rawDest = rt; tnew = TNEW_1;
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        rawDest = rt; tnew = TNEW_2; tuseRs = TUSE_1;
      end
      OP_SW, OP_SH, OP_SB: begin
        tuseRs = TUSE_1; tuseRt = TUSE_2;
      end
      OP_BEQ, OP_BNE: begin
        tuseRs = TUSE_0; tuseRt = TUSE_0;
      end
      OP_BGTZ, OP_BLEZ, OP_REGIMM: tuseRs = TUSE_0;
      OP_JAL: begin
        rawDest = 5'd31; tnew = TNEW_0;
      end
      default: ;
    endcase
    dest = rawDest;
    if (rawDest == '0) tnew = TNEW_0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W destination tracking, D-stage stall and HI/LO busy counter
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);

  logic [4:0]  decDest;
  logic [1:0]  decTnew;
  logic [1:0]  decTuseRs;
  logic [1:0]  decTuseRt;
  logic        decIsMd;
  logic [3:0]  decMdLen;

  logic [4:0]  srcRs;
  logic [4:0]  srcRt;

  stageEntry_t stageE;
  stageEntry_t stageM;
  logic [4:0]  destW;
  logic [3:0]  mdCnt;

  logic        mdBusy;
  logic        dataStall;
  logic        mdStall;
  logic        stallD;

  hazard_decode #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) uDecode (
    .instr (bus.Instr_D),
    .dest  (decDest),
    .tnew  (decTnew),
    .tuseRs(decTuseRs),
    .tuseRt(decTuseRt),
    .isMd  (decIsMd),
    .mdLen (decMdLen)
  );

  assign srcRs = bus.Instr_D[25:21];
  assign srcRt = bus.Instr_D[20:16];

  // An operand needs a stall when its producer is in flight and not ready by its use time
  function automatic logic srcHazard(input logic [4:0] src, input logic [1:0] tuse,
                                     input stageEntry_t e);
    return (e.dest != '0) && (e.dest == src) && (tuse < e.tnew);
  endfunction

  // W is omitted: its Tnew has always reached zero
  always_comb begin
    mdBusy    = (mdCnt != '0);
    dataStall = srcHazard(srcRs, decTuseRs, stageE) | srcHazard(srcRt, decTuseRt, stageE) |
                srcHazard(srcRs, decTuseRs, stageM) | srcHazard(srcRt, decTuseRt, stageM);
    mdStall   = decIsMd & mdBusy;
    stallD    = dataStall | mdStall;
  end

  // Advance the stage entries every cycle; a stalled D instruction becomes a bubble in E
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stageE <= '0;
      stageM <= '0;
      destW  <= '0;
    end else begin
      stageE <= stallD ? '0 : stageEntry_t'{dest: decDest, tnew: decTnew};
      stageM <= stageEntry_t'{dest: stageE.dest, tnew: tnewDec(stageE.tnew)};
      destW  <= stageM.dest;
    end
  end

  // Busy counter reloads only when a mult/div actually leaves D
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdCnt <= '0;
    end else if (!stallD && (decMdLen != '0)) begin
      mdCnt <= decMdLen;
    end else if (mdCnt != '0) begin
      mdCnt <= mdCnt - 4'd1;
    end
  end

  assign bus.stall   = stallD;
  assign bus.Write_E = stageE.dest;
  assign bus.Write_M = stageM.dest;
  assign bus.Write_W = destW;
  assign bus.Tnew_E  = stageE.tnew;
  assign bus.Tnew_M  = stageM.tnew;
  assign bus.md_busy = mdBusy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed checks of hazard_scoreboard against a pipeline model
module tb_hazard_scoreboard;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  hazard_scoreboard_if hzIf ();

  hazard_scoreboard #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (hzIf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int dest;
    int tnew;
    int tuseRs;
    int tuseRt;
    int mdLen;
    bit isMd;
  } decM_t;

  function automatic decM_t decodeModel(input logic [31:0] ins);
    decM_t d;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    int rt = int'(ins[20:16]);
    int rd = int'(ins[15:11]);
    d = '{dest: 0, tnew: 0, tuseRs: 3, tuseRt: 3, mdLen: 0, isMd: 1'b0};
    if (op == 6'h00) begin
      if (fn inside {6'h21, 6'h23, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                     6'h2a, 6'h2b, 6'h04, 6'h06, 6'h07, 6'h0a})
        d = '{rd, 1, 1, 1, 0, 1'b0};
      else if (fn inside {6'h00, 6'h02, 6'h03}) d = '{rd, 1, 3, 1, 0, 1'b0};
      else if (fn inside {6'h10, 6'h12})        d = '{rd, 1, 3, 3, 0, 1'b1};
      else if (fn inside {6'h11, 6'h13})        d = '{0, 0, 1, 3, 0, 1'b1};
      else if (fn inside {6'h18, 6'h19})        d = '{0, 0, 1, 1, MULT_N, 1'b1};
      else if (fn inside {6'h1a, 6'h1b})        d = '{0, 0, 1, 1, DIV_N, 1'b1};
      else if (fn == 6'h08)                     d = '{0, 0, 0, 3, 0, 1'b0};
      else if (fn == 6'h09)                     d = '{rd, 0, 0, 3, 0, 1'b0};
    end
    else if (op inside {6'h0d, 6'h0c, 6'h0e, 6'h08, 6'h09, 6'h0a, 6'h0b}) d = '{rt, 1, 1, 3, 0, 1'b0};
    else if (op == 6'h0f)                               d = '{rt, 1, 3, 3, 0, 1'b0};
    else if (op inside {6'h23, 6'h20, 6'h24, 6'h21, 6'h25}) d = '{rt, 2, 1, 3, 0, 1'b0};
    else if (op inside {6'h2b, 6'h29, 6'h28})           d = '{0, 0, 1, 2, 0, 1'b0};
    else if (op inside {6'h04, 6'h05})                  d = '{0, 0, 0, 0, 0, 1'b0};
    else if (op inside {6'h07, 6'h06, 6'h01})           d = '{0, 0, 0, 3, 0, 1'b0};
    else if (op == 6'h03)                               d = '{31, 0, 3, 3, 0, 1'b0};
    if (d.dest == 0) d.tnew = 0;
    return d;
  endfunction

  // Pipeline history: index 0 = E, 1 = M, 2 = W; Tnew kept as issued and aged by index
  int mDest [3] = '{0, 0, 0};
  int mT0   [3] = '{0, 0, 0};
  int edgeIdx = 0;
  int mdEnd   = 0;

  function automatic int remaining(input int k);
    return (mT0[k] - k > 0) ? mT0[k] - k : 0;
  endfunction

  function automatic bit modelStall(input logic [31:0] ins);
    decM_t d = decodeModel(ins);
    int rs = int'(ins[25:21]);
    int rt = int'(ins[20:16]);
    bit s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (mDest[k] != 0 && mDest[k] == rs && d.tuseRs < remaining(k)) s = 1'b1;
      if (mDest[k] != 0 && mDest[k] == rt && d.tuseRt < remaining(k)) s = 1'b1;
    end
    if (d.isMd && edgeIdx < mdEnd) s = 1'b1;
    return s;
  endfunction

  always @(posedge clk or negedge reset) begin : modelUpdate
    decM_t d;
    bit st;
    if (!reset) begin
      mDest = '{0, 0, 0};
      mT0   = '{0, 0, 0};
      edgeIdx = 0;
      mdEnd   = 0;
    end else begin
      d  = decodeModel(hzIf.Instr_D);
      st = modelStall(hzIf.Instr_D);
      mDest[2] = mDest[1]; mT0[2] = mT0[1];
      mDest[1] = mDest[0]; mT0[1] = mT0[0];
      mDest[0] = st ? 0 : d.dest;
      mT0[0]   = st ? 0 : d.tnew;
      edgeIdx++;
      if (!st && d.mdLen > 0) mdEnd = edgeIdx + d.mdLen;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (reset) begin
      check("stall",   32'(hzIf.stall),   32'(modelStall(hzIf.Instr_D)));
      check("Write_E", 32'(hzIf.Write_E), mDest[0]);
      check("Write_M", 32'(hzIf.Write_M), mDest[1]);
      check("Write_W", 32'(hzIf.Write_W), mDest[2]);
      if (mDest[0] != 0) check("Tnew_E", 32'(hzIf.Tnew_E), remaining(0));
      if (mDest[1] != 0) check("Tnew_M", 32'(hzIf.Tnew_M), remaining(1));
      check("md_busy", 32'(hzIf.md_busy), 32'(edgeIdx < mdEnd));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Present an instruction in D and hold it until accepted; ends at the negedge before acceptance
  task automatic issue(input logic [31:0] ins, output int stalls);
    @(posedge clk);
    #1;
    hzIf.Instr_D = ins;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (hzIf.stall !== 1'b1) break;
      stalls++;
      if (stalls > 40) begin
        tests++;
        failed++;
        $display("FAIL issue_timeout: instr %h still stalled after %0d cycles", ins, stalls);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush();
    int s;
    for (int i = 0; i < 3; i++) issue(32'h0, s);
  endtask

  task automatic pair(input string name, input logic [31:0] a, input logic [31:0] b,
                      input int expStalls);
    int s;
    flush();
    issue(a, s);
    issue(b, s);
    check(name, s, expStalls);
  endtask

  logic [5:0] rFn [0:28] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0a,
                             6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b,
                             6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2a, 6'h2b, 6'h3f, 6'h05};
  logic [5:0] iOp [0:24] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                             6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23,
                             6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h3f, 6'h1c};

  function automatic logic [31:0] randInstr();
    int rs = $urandom_range(0, 7);
    int rt = $urandom_range(0, 7);
    int rd = $urandom_range(0, 7);
    if ($urandom_range(0, 1) == 0)
      return rtype(rs, rt, rd, $urandom_range(0, 31), rFn[$urandom_range(0, 28)]);
    return itype(iOp[$urandom_range(0, 24)], rs, rt, $urandom_range(0, 65535));
  endfunction

  // ---------------- main sequence ----------------
  initial begin : mainSeq
    int s;
    hzIf.Instr_D = rtype(8, 8, 9, 0, 6'h21);
    #12;
    check("reset_stall",   32'(hzIf.stall),   0);
    check("reset_Write_E", 32'(hzIf.Write_E), 0);
    check("reset_Write_W", 32'(hzIf.Write_W), 0);
    check("reset_md_busy", 32'(hzIf.md_busy), 0);
    @(negedge clk);
    #2 reset = 1'b1;

    // load-use into ALU: one bubble, then the load sits in M with Tnew 1
    flush();
    issue(itype(6'h23, 1, 8, 0), s);
    issue(rtype(8, 0, 9, 0, 6'h21), s);
    check("lw_addu_stalls", s, 1);
    check("lw_addu_Write_M", 32'(hzIf.Write_M), 8);
    check("lw_addu_Tnew_M",  32'(hzIf.Tnew_M), 1);
    check("lw_addu_Write_E", 32'(hzIf.Write_E), 0);

    pair("lw_beq_stalls",   itype(6'h23, 1, 8, 0), itype(6'h04, 8, 0, 4), 2);
    pair("ori_beq_stalls",  itype(6'h0d, 1, 8, 5), itype(6'h04, 8, 0, 4), 1);
    pair("zero_beq_stalls", rtype(1, 2, 0, 0, 6'h21), itype(6'h04, 0, 0, 4), 0);

    pair("jal_jr_stalls", {6'h03, 26'd100}, rtype(31, 0, 0, 0, 6'h08), 0);
    check("jal_Write_E", 32'(hzIf.Write_E), 31);
    check("jal_Tnew_E",  32'(hzIf.Tnew_E), 0);

    pair("div_mflo_stalls", rtype(1, 2, 0, 0, 6'h1a), rtype(0, 0, 3, 0, 6'h12), 10);
    check("div_md_busy_done", 32'(hzIf.md_busy), 0);
    pair("mult_mflo_stalls", rtype(1, 2, 0, 0, 6'h18), rtype(0, 0, 3, 0, 6'h12), 5);

    pair("ori_sw_stalls", itype(6'h0d, 1, 8, 5), itype(6'h2b, 9, 8, 0), 0);
    pair("lw8_sw_stalls", itype(6'h23, 1, 8, 0), itype(6'h2b, 9, 8, 0), 0);
    pair("lw9_sw_stalls", itype(6'h23, 1, 9, 0), itype(6'h2b, 9, 8, 0), 1);

    // Reset mid-run: load $8 in E, busy counter at 7
    flush();
    issue(rtype(1, 2, 0, 0, 6'h1a), s);
    issue(32'h0, s);
    issue(32'h0, s);
    issue(itype(6'h23, 1, 8, 0), s);
    @(posedge clk);
    #1;
    hzIf.Instr_D = rtype(8, 8, 9, 0, 6'h21);
    #2;
    check("pre_reset_stall",   32'(hzIf.stall),   1);
    check("pre_reset_Write_E", 32'(hzIf.Write_E), 8);
    check("pre_reset_md_busy", 32'(hzIf.md_busy), 1);
    reset = 1'b0;
    #1;
    check("async_reset_stall",   32'(hzIf.stall),   0);
    check("async_reset_Write_E", 32'(hzIf.Write_E), 0);
    check("async_reset_Write_M", 32'(hzIf.Write_M), 0);
    check("async_reset_Write_W", 32'(hzIf.Write_W), 0);
    check("async_reset_Tnew_E",  32'(hzIf.Tnew_E),  0);
    check("async_reset_Tnew_M",  32'(hzIf.Tnew_M),  0);
    check("async_reset_md_busy", 32'(hzIf.md_busy), 0);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;

    // Randomized traffic, checked each cycle by the compare process
    for (int i = 0; i < 1500; i++) issue(randInstr(), s);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog expired");
  end

endmodule
